// File: rtl/control_sequencer_p_pkg.sv
// control_sequencer_p_pkg
// Shared constants for the control sequencer: opcode values, addressing-mode
// values, the state encoding exposed on the `state` port, and the instruction
// classes the decoder hands back to the sequencer.
package control_sequencer_p_pkg;

  localparam int OPCODE_W = 5;
  localparam int MODE_W   = 2;
  localparam int STATE_W  = 5;

  // Opcode values (top five bits of the instruction word)
  localparam logic [OPCODE_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_AND   = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_OR    = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_STORE = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_MOVE  = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 5'b11111;

  // Addressing modes. Only LOAD looks at the mode: MODE_IMM takes its
  // operand from the next fetched word, every other mode goes to data memory.
  localparam logic [MODE_W-1:0] MODE_REG      = 2'b00;
  localparam logic [MODE_W-1:0] MODE_INDIRECT = 2'b01;
  localparam logic [MODE_W-1:0] MODE_IMM      = 2'b10;
  localparam logic [MODE_W-1:0] MODE_OFFSET   = 2'b11;

  // Sequencer states; the numeric values are visible on the `state` port.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 5'd0,
    ST_FETCH    = 5'd1,
    ST_DECODE   = 5'd2,
    ST_IMM      = 5'd3,
    ST_EXEC     = 5'd4,
    ST_MEM_WAIT = 5'd5,
    ST_WB       = 5'd6,
    ST_HALT     = 5'd31
  } state_t;

  // What the sequencer must do with the word held in IR.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_MOVE,
    CLS_LOAD_IMM,
    CLS_LOAD_MEM,
    CLS_STORE,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/control_sequencer_p_instr_decoder.sv
// control_sequencer_p_instr_decoder
// Purely combinational classification of an opcode/mode pair.
// Ports:
//   opcode  in  5  opcode field of IR
//   mode    in  2  mode field of IR
//   iclass  out    instruction class (drives the sequencer's next state)
//   illegal out 1  opcode is not one of the defined values
module control_sequencer_p_instr_decoder
  import control_sequencer_p_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [MODE_W-1:0]   mode,
  output instr_class_t        iclass,
  output logic                illegal
);

  always_comb begin
    iclass = CLS_ILLEGAL;
    case (opcode)
      OP_NOP:                        iclass = CLS_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR: iclass = CLS_ALU;
      OP_MOVE:                       iclass = CLS_MOVE;
      OP_LOAD:  iclass = (mode == MODE_IMM) ? CLS_LOAD_IMM : CLS_LOAD_MEM;
      OP_STORE:                      iclass = CLS_STORE;
      OP_HALT:                       iclass = CLS_HALT;
      default:                       iclass = CLS_ILLEGAL;
    endcase
    illegal = (iclass == CLS_ILLEGAL);
  end

endmodule

// File: rtl/control_sequencer_p.sv
// control_sequencer_p
// Multi-cycle instruction sequencer: fetches a word, decodes it, and walks
// through EXEC / IMM / MEM_WAIT / WB, producing register-file, ALU and
// data-memory control strobes.
// Ports:
//   clock        in   1        system clock
//   reset        in   1        asynchronous reset, active low
//   instr        in   INSTR_W  fetched word (instruction or immediate)
//   instr_valid  in   1        instr holds a valid word this cycle
//   fetch_req    out  1        word request (FETCH and IMM)
//   mem_ready    in   1        data-memory access complete
//   mem_rd       out  1        load strobe
//   mem_wr       out  1        store strobe
//   state        out  5        current state encoding
//   src_sel      out  REG_SEL_W source register select
//   dst_sel      out  REG_SEL_W destination register select
//   alu_op       out  5        opcode presented to the ALU
//   reg_we       out  1        register-file write enable
//   imm_out      out  INSTR_W  latched immediate word
//   imm_sel      out  1        write-back takes imm_out instead of the ALU
//   pc_inc       out  1        program-counter increment pulse
//   halted       out  1        sequencer is in HALT
//   illegal      out  1        sticky: an undefined opcode was decoded
//   timeout      out  1        sticky: a memory access was aborted
module control_sequencer_p
  import control_sequencer_p_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int REG_SEL_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 fetch_req,
  input  logic                 mem_ready,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [STATE_W-1:0]   state,
  output logic [REG_SEL_W-1:0] src_sel,
  output logic [REG_SEL_W-1:0] dst_sel,
  output logic [OPCODE_W-1:0]  alu_op,
  output logic                 reg_we,
  output logic [INSTR_W-1:0]   imm_out,
  output logic                 imm_sel,
  output logic                 pc_inc,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout
);

  // Last MEM_WAIT count value before the access is abandoned.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [INSTR_W-1:0]   imm_q, imm_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic                 fetch_req_q, fetch_req_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 reg_we_q, reg_we_d;
  logic                 pc_inc_q, pc_inc_d;
  logic                 imm_sel_q, imm_sel_d;

  // IR fields
  logic [OPCODE_W-1:0]  ir_opcode;
  logic [MODE_W-1:0]    ir_mode;
  logic [REG_SEL_W-1:0] ir_src;
  logic [REG_SEL_W-1:0] ir_dst;
  logic                 unused_ir_bits;

  assign ir_opcode = ir_q[INSTR_W-1 -: OPCODE_W];
  assign ir_mode   = ir_q[INSTR_W-6 -: MODE_W];
  assign ir_src    = ir_q[INSTR_W-9 -: REG_SEL_W];
  assign ir_dst    = ir_q[INSTR_W-9-REG_SEL_W -: REG_SEL_W];
  // Spare bits of the instruction word carry no meaning.
  assign unused_ir_bits = ^ir_q;

  instr_class_t iclass;
  logic         dec_illegal;

  // IR only changes on the FETCH->DECODE edge, so the class derived from it
  // stays valid for every state of the instruction.
  control_sequencer_p_instr_decoder instr_decoder (
    .opcode  (ir_opcode),
    .mode    (ir_mode),
    .iclass  (iclass),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    imm_d      = imm_q;
    wait_cnt_d = wait_cnt_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    pc_inc_d   = 1'b0;
    imm_sel_d  = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (instr_valid) begin
          ir_d     = instr;
          pc_inc_d = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        wait_cnt_d = '0;
        case (iclass)
          CLS_LOAD_IMM:         state_d = ST_IMM;
          CLS_ALU, CLS_MOVE:    state_d = ST_EXEC;
          CLS_LOAD_MEM,
          CLS_STORE:            state_d = ST_MEM_WAIT;
          CLS_NOP:              state_d = ST_FETCH;
          CLS_HALT:             state_d = ST_HALT;
          default: begin
            illegal_d = illegal_q | dec_illegal;
            state_d   = ST_FETCH;
          end
        endcase
      end

      ST_IMM: begin
        if (instr_valid) begin
          imm_d     = instr;
          pc_inc_d  = 1'b1;
          imm_sel_d = 1'b1;
          state_d   = ST_WB;
        end
      end

      ST_EXEC: state_d = ST_WB;

      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = (iclass == CLS_LOAD_MEM) ? ST_WB : ST_FETCH;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Abandon the access: no write-back for an aborted load.
          timeout_d = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      ST_WB: state_d = ST_FETCH;

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase

    // Strobes are flopped from the next state so they line up with the
    // state they belong to and never glitch.
    fetch_req_d = (state_d == ST_FETCH) || (state_d == ST_IMM);
    mem_rd_d    = (state_d == ST_MEM_WAIT) && (iclass == CLS_LOAD_MEM);
    mem_wr_d    = (state_d == ST_MEM_WAIT) && (iclass == CLS_STORE);
    reg_we_d    = (state_d == ST_WB);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      imm_q       <= '0;
      wait_cnt_q  <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      fetch_req_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      pc_inc_q    <= 1'b0;
      imm_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      wait_cnt_q  <= wait_cnt_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      fetch_req_q <= fetch_req_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      reg_we_q    <= reg_we_d;
      pc_inc_q    <= pc_inc_d;
      imm_sel_q   <= imm_sel_d;
    end
  end

  assign state     = state_q;
  assign fetch_req = fetch_req_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign reg_we    = reg_we_q;
  assign pc_inc    = pc_inc_q;
  assign imm_sel   = imm_sel_q;
  assign imm_out   = imm_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign halted    = (state_q == ST_HALT);
  // Selects follow IR for the whole life of the instruction.
  assign src_sel   = ir_src;
  assign dst_sel   = ir_dst;
  // Opcode is held through WB so the write-back sees a stable ALU result
  // (MOVE uses the ALU pass path).
  assign alu_op    = (state_q == ST_EXEC || state_q == ST_WB) ? ir_opcode : '0;

endmodule

// File: tb/tb_control_sequencer_p.sv
// tb_control_sequencer_p
// Table-driven bench: each row is one instruction with its expected
// observable effects; expectations are queued when the instruction is issued
// and compared when the sequencer returns to FETCH. Hand-written sequences
// cover reset, the NOP state trace, HALT and reset during MEM_WAIT.
module tb_control_sequencer_p;

  localparam logic [4:0] S_IDLE = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2,
                         S_IMM = 5'd3, S_EXEC = 5'd4, S_MW = 5'd5,
                         S_WB = 5'd6, S_HALT = 5'd31;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        fetch_req;
  logic        mem_ready = 1'b0;
  logic        mem_rd, mem_wr;
  logic [4:0]  state;
  logic [2:0]  src_sel, dst_sel;
  logic [4:0]  alu_op;
  logic        reg_we;
  logic [15:0] imm_out;
  logic        imm_sel, pc_inc, halted, illegal, timeout;

  control_sequencer_p #(.INSTR_W(16), .REG_SEL_W(3), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .fetch_req(fetch_req), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .state(state), .src_sel(src_sel), .dst_sel(dst_sel),
    .alu_op(alu_op), .reg_we(reg_we), .imm_out(imm_out), .imm_sel(imm_sel),
    .pc_inc(pc_inc), .halted(halted), .illegal(illegal), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cycles; int we; int we_cycle; int src; int dst; int isel; int alu;
    int rd; int wr; int pc; int ill; int tmo; int imm;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] imm_word;
    int          ready_after;  // MEM_WAIT cycles before mem_ready; -1 = never
    obs_t        e;
  } vec_t;

  vec_t tbl[$];
  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] md,
                                     input logic [2:0] s, input logic [2:0] d);
    return {op, md, 1'b0, s, d, 2'b00};
  endfunction

  function automatic obs_t obs_zero();
    obs_t o;
    o.cycles = 0; o.we = 0; o.we_cycle = 0; o.src = 0; o.dst = 0; o.isel = 0;
    o.alu = 0; o.rd = 0; o.wr = 0; o.pc = 0; o.ill = 0; o.tmo = 0; o.imm = 0;
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_row(input logic [15:0] ins, input logic [15:0] imm, input int rdy,
                         input int cyc, input int we, input int wec, input int src,
                         input int dst, input int isel, input int alu, input int rd,
                         input int wr, input int pc, input int ill, input int tmo,
                         input int immo);
    vec_t v;
    v.ins = ins; v.imm_word = imm; v.ready_after = rdy;
    v.e.cycles = cyc; v.e.we = we; v.e.we_cycle = wec; v.e.src = src; v.e.dst = dst;
    v.e.isel = isel; v.e.alu = alu; v.e.rd = rd; v.e.wr = wr; v.e.pc = pc;
    v.e.ill = ill; v.e.tmo = tmo; v.e.imm = immo;
    tbl.push_back(v);
  endtask

  task automatic compare_obs(input int r, input obs_t a, input obs_t e);
    check($sformatf("row%0d cycles", r), a.cycles, e.cycles);
    check($sformatf("row%0d reg_we_count", r), a.we, e.we);
    check($sformatf("row%0d reg_we_cycle", r), a.we_cycle, e.we_cycle);
    check($sformatf("row%0d src_sel", r), a.src, e.src);
    check($sformatf("row%0d dst_sel", r), a.dst, e.dst);
    check($sformatf("row%0d imm_sel", r), a.isel, e.isel);
    check($sformatf("row%0d alu_op", r), a.alu, e.alu);
    check($sformatf("row%0d mem_rd_cycles", r), a.rd, e.rd);
    check($sformatf("row%0d mem_wr_cycles", r), a.wr, e.wr);
    check($sformatf("row%0d pc_inc_count", r), a.pc, e.pc);
    check($sformatf("row%0d illegal", r), a.ill, e.ill);
    check($sformatf("row%0d timeout", r), a.tmo, e.tmo);
    check($sformatf("row%0d imm_out", r), a.imm, e.imm);
  endtask

  task automatic run_row(input int r);
    vec_t v = tbl[r];
    obs_t o = obs_zero();
    obs_t e;
    int   n = 0;
    int   mw = 0;
    bit   done = 0;
    check($sformatf("row%0d start_state", r), int'(state), int'(S_FETCH));
    sb_q.push_back(v.e);
    instr = v.ins; instr_valid = 1'b1; mem_ready = 1'b0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (pc_inc) o.pc++;
      if (mem_rd) o.rd++;
      if (mem_wr) o.wr++;
      if (state == S_EXEC) o.alu = int'(alu_op);
      if (reg_we) begin
        o.we++; o.we_cycle = n + 1;
        o.src = int'(src_sel); o.dst = int'(dst_sel); o.isel = int'(imm_sel);
      end
      if (state == S_IMM) begin
        instr = v.imm_word; instr_valid = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
      if (state == S_MW) begin
        mw++;
        mem_ready = (v.ready_after >= 0) && (mw > v.ready_after);
      end else begin
        mem_ready = 1'b0;
      end
      if (state == S_FETCH) done = 1;
    end
    instr_valid = 1'b0; mem_ready = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL row%0d return_to_fetch: got no FETCH required FETCH within 40 cycles", r);
    end
    o.cycles = n; o.ill = int'(illegal); o.tmo = int'(timeout); o.imm = int'(imm_out);
    e = sb_q.pop_front();
    compare_obs(r, o, e);
    $display("row%0d instr=%04h cycles=%0d reg_we=%0d alu=%0d rd=%0d wr=%0d",
             r, v.ins, o.cycles, o.we, o.alu, o.rd, o.wr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_seen;
    int bad_state;
    int strobes;

    //       instr                    imm      rdy cyc we wec src dst isel alu rd wr pc ill tmo imm
    add_row(mk(5'b00000,2'b00,0,1),   16'h0,    0,  2, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    add_row(mk(5'b00001,2'b00,1,2),   16'h0,    0,  4, 1, 4, 1, 2, 0,  1, 0, 0, 1, 0, 0, 0);
    add_row(mk(5'b00010,2'b00,5,6),   16'h0,    0,  4, 1, 4, 5, 6, 0,  2, 0, 0, 1, 0, 0, 0);
    add_row(mk(5'b00011,2'b01,7,0),   16'h0,    0,  4, 1, 4, 7, 0, 0,  3, 0, 0, 1, 0, 0, 0);
    add_row(mk(5'b00100,2'b00,3,4),   16'h0,    0,  4, 1, 4, 3, 4, 0,  4, 0, 0, 1, 0, 0, 0);
    add_row(mk(5'b10010,2'b00,2,7),   16'h0,    0,  4, 1, 4, 2, 7, 0, 18, 0, 0, 1, 0, 0, 0);
    add_row(mk(5'b10000,2'b10,0,3),   16'h0018, 0,  4, 1, 4, 0, 3, 1,  0, 0, 0, 2, 0, 0, 24);
    add_row(mk(5'b10000,2'b00,4,5),   16'h0,    2,  6, 1, 6, 4, 5, 0,  0, 3, 0, 1, 0, 0, 24);
    add_row(mk(5'b10001,2'b00,6,1),   16'h0,    0,  3, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 24);
    add_row(mk(5'b01111,2'b00,0,0),   16'h0,    0,  2, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 24);
    add_row(mk(5'b00000,2'b00,0,0),   16'h0,    0,  2, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 24);
    add_row(mk(5'b10001,2'b01,0,0),   16'h0,   -1, 17, 0, 0, 0, 0, 0,  0, 0,15, 1, 1, 1, 24);
    add_row(mk(5'b00001,2'b00,3,3),   16'h0,    0,  4, 1, 4, 3, 3, 0,  1, 0, 0, 1, 1, 1, 24);

    // Reset: asynchronous assertion, held for two clocks.
    #1 reset = 1'b0;
    #2;
    check("reset_async_state", int'(state), int'(S_IDLE));
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", int'(state), int'(S_IDLE));
    check("reset_strobes", int'({fetch_req, mem_rd, mem_wr, reg_we, pc_inc, imm_sel}), 0);
    check("reset_flags", int'({halted, illegal, timeout}), 0);
    check("reset_imm_out", int'(imm_out), 0);

    // NOP trace: IDLE, FETCH, DECODE, FETCH.
    instr = 16'h0004; instr_valid = 1'b1;
    reset = 1'b1;
    we_seen = 0;
    check("nop_trace_s0", int'(state), int'(S_IDLE));
    @(posedge clock); #1; we_seen += int'(reg_we);
    check("nop_trace_s1", int'(state), int'(S_FETCH));
    check("nop_fetch_req", int'(fetch_req), 1);
    @(posedge clock); #1; we_seen += int'(reg_we);
    check("nop_trace_s2", int'(state), int'(S_DECODE));
    @(posedge clock); #1; we_seen += int'(reg_we);
    instr_valid = 1'b0;
    check("nop_trace_s3", int'(state), int'(S_FETCH));
    check("nop_no_reg_we", we_seen, 0);
    $display("nop trace done reg_we_seen=%0d", we_seen);

    for (int r = 0; r < tbl.size(); r++) run_row(r);

    // HALT: terminal, ignores instr.
    instr = 16'hF800; instr_valid = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("halt_state", int'(state), int'(S_HALT));
    check("halt_halted", int'(halted), 1);
    bad_state = 0; strobes = 0;
    for (int i = 0; i < 20; i++) begin
      instr = 16'($urandom); instr_valid = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      if (state != S_HALT || !halted) bad_state++;
      if (fetch_req || reg_we || pc_inc || mem_rd || mem_wr) strobes++;
    end
    instr_valid = 1'b0; mem_ready = 1'b0;
    check("halt_stays", bad_state, 0);
    check("halt_no_strobes", strobes, 0);
    $display("halt hold done bad_state=%0d strobes=%0d", bad_state, strobes);
    @(posedge clock); #3 reset = 1'b0;
    #1;
    check("halt_reset_state", int'(state), int'(S_IDLE));
    check("halt_reset_halted", int'(halted), 0);
    check("halt_reset_sticky", int'({illegal, timeout}), 0);
    check("halt_reset_imm_out", int'(imm_out), 0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    check("rerun_fetch", int'(state), int'(S_FETCH));

    // Reset in the middle of MEM_WAIT drops the strobe at once; no write follows.
    instr = mk(5'b10000, 2'b00, 1, 1); instr_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clock); #1; instr_valid = 1'b0;
    @(posedge clock); #1;
    check("mw_state", int'(state), int'(S_MW));
    check("mw_mem_rd", int'(mem_rd), 1);
    @(posedge clock); #3 reset = 1'b0;
    #1;
    check("mw_reset_mem_rd", int'(mem_rd), 0);
    check("mw_reset_state", int'(state), int'(S_IDLE));
    @(posedge clock); #1 reset = 1'b1;
    mem_ready = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      we_seen += int'(reg_we);
    end
    mem_ready = 1'b0;
    check("mw_reset_no_reg_we", we_seen, 0);
    check("mw_reset_end_state", int'(state), int'(S_FETCH));
    $display("reset mid-MEM_WAIT done reg_we_seen=%0d", we_seen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer_p.md
CONTROL_SEQUENCER_P -- requirements
Module: control_sequencer_p

Interface
REQ-001 Parameter INSTR_W, default 16, instruction/immediate word width; SHALL be at least 16.
REQ-002 Parameter REG_SEL_W, default 3, register-select width; SHALL satisfy INSTR_W >= 8 + 2*REG_SEL_W.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum MEM_WAIT cycles before abort; 4-bit counter.
REQ-004 Ports SHALL be: clock in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-005 Ports SHALL be: instr in INSTR_W fetched word; instr_valid in 1 instr holds a valid word this cycle; fetch_req out 1 word request.
REQ-006 Ports SHALL be: mem_ready in 1 data-memory done; mem_rd out 1 load strobe; mem_wr out 1 store strobe.
REQ-007 Ports SHALL be: state out 5 current state; src_sel out REG_SEL_W; dst_sel out REG_SEL_W; alu_op out 5 opcode to ALU; reg_we out 1; imm_out out INSTR_W; imm_sel out 1; pc_inc out 1.
REQ-008 Ports SHALL be: halted out 1; illegal out 1 sticky bad-opcode flag; timeout out 1 sticky memory-abort flag.

Function
REQ-009 Instruction fields: opcode [INSTR_W-1 -: 5], mode [INSTR_W-6 -: 2], src [INSTR_W-9 -: REG_SEL_W], dst [INSTR_W-9-REG_SEL_W -: REG_SEL_W]; remaining low bits ignored.
REQ-010 Opcodes: NOP 00000, ADD 00001, SUB 00010, AND 00011, OR 00100, LOAD 10000, STORE 10001, MOVE 10010, HALT 11111; any other is illegal.
REQ-011 State encodings: IDLE 0, FETCH 1, DECODE 2, IMM 3, EXEC 4, MEM_WAIT 5, WB 6, HALT 31.
REQ-012 IDLE -> FETCH unconditionally on the first clock after reset release.
REQ-013 FETCH: fetch_req=1; on instr_valid latch instr into IR, pulse pc_inc, go DECODE; else stay.
REQ-014 DECODE: LOAD with mode=10 -> IMM; ALU opcodes and MOVE -> EXEC; LOAD (other modes)/STORE -> MEM_WAIT; NOP -> FETCH; HALT -> HALT; illegal -> set illegal, go FETCH.
REQ-015 IMM: fetch_req=1; on instr_valid latch word into imm_out, pulse pc_inc, go WB with imm_sel=1; else stay.
REQ-016 EXEC: alu_op=opcode, one cycle, go WB.
REQ-017 MEM_WAIT: mem_rd=1 for LOAD, mem_wr=1 for STORE, held until mem_ready; LOAD -> WB, STORE -> FETCH.
REQ-018 MEM_WAIT timeout: after MEM_TIMEOUT cycles without mem_ready, set timeout, drop strobes, go FETCH with no write.
REQ-019 WB: reg_we=1 for exactly one cycle, dst_sel=IR dst, go FETCH; imm_sel=1 only for immediate LOAD.
REQ-020 MOVE: src_sel=IR src, dst_sel=IR dst, WB writes the src value through the ALU pass path.
REQ-021 HALT: halted=1; terminal; only reset leaves it; instr ignored.
REQ-022 src_sel/dst_sel SHALL be driven from IR in every state after DECODE until the next FETCH.
REQ-023 All strobes (fetch_req, mem_rd, mem_wr, reg_we, pc_inc) SHALL be registered Moore outputs of the current state.
REQ-024 Latency: register-to-register ALU op = 4 cycles FETCH-to-FETCH with instr_valid already high.

Reset
REQ-025 reset low SHALL immediately force state=IDLE, IR=0, imm_out=0, all strobes 0, halted=0, illegal=0, timeout=0, regardless of clock.
REQ-026 Reset asserted mid-MEM_WAIT SHALL drop mem_rd/mem_wr asynchronously; no reg_we pulse follows.
REQ-027 illegal and timeout SHALL clear only on reset.

Structure
REQ-028 Opcode values, mode values and state encodings SHALL live in the shared constants file.
REQ-029 One sub-module SHALL be used: instr_decoder (combinational, opcode/mode -> next-class and illegal).

Verification
REQ-030 Reset low 2 cycles then high, instr_valid=1, instr=0x0004 (NOP) -> states 0,1,2,1; no reg_we.
REQ-031 LOAD imm 16'b10000_10_0_000_011_00 then word 0x0018 -> IMM state, imm_out=0x0018, dst_sel=3, one reg_we with imm_sel=1.
REQ-032 ADD 16'b00001_00_0_001_010_00 -> src_sel=1, dst_sel=2, alu_op=00001, reg_we in cycle 4.
REQ-033 STORE with mem_ready held low -> mem_wr for 15 cycles, then timeout=1, state FETCH, no reg_we.
REQ-034 Opcode 01111 -> illegal=1, returns to FETCH; subsequent NOP executes normally.
REQ-035 HALT 0xF800 -> state 31, halted=1, stays for 20 cycles of changing instr; reset returns IDLE.
